screen_seq: RTL and testbench
=============================

Name: screen_seq

Overview:
Frame-synchronous screen sequencer that drives the top-level menu/game/credits video mux.
- Takes raw mouse clicks, the board button and a game-over flag, and decides which screen is shown.
- Switches screens only at frame boundaries and inserts black frames between screens.
- Resets the game engine on every entry to the game screen.

Parameters:
BTN_X_MIN, 362, left edge of menu buttons (inclusive, pixels)
BTN_X_MAX, 674, right edge of menu buttons (inclusive)
PLAY_Y_MIN / PLAY_Y_MAX, 46 / 146, vertical extent of PLAY button (inclusive)
CRED_Y_MIN / CRED_Y_MAX, 622 / 722, vertical extent of CREDITS button (inclusive)
DEBOUNCE_CYCLES, 650000, consecutive stable-high cycles before a button press is accepted
BLANK_FRAMES, 2, number of black frames inserted per screen change (1..15)

Ports:
clk  in  1  pixel clock
rst  in  1  reset; asynchronous, active-low
vblnk_in  in  1  vertical blank from timing generator
mouse_left  in  1  left mouse button level, clk domain
xpos  in  12  mouse x
ypos  in  12  mouse y
button  in  1  board button, asynchronous, bounces
game_over  in  1  level from game engine, high when a match ends
screen_sel  out  2  selected screen: 0 MENU, 1 GAME, 2 CREDITS
blank_out  out  1  high: mux must force rgb to 0
game_rst  out  1  high: hold game engine in reset
busy  out  1  high while a transition is pending or blanking

Behaviour:
- Reset (rst=0, async): state MENU, screen_sel=0, blank_out=0, game_rst=1, busy=0. All counters and synchronisers clear.
- Frame start (fs): one-cycle pulse on the registered rising edge of vblnk_in.
- Click event: registered rising edge of mouse_left. Holding the button never retriggers.
- Hit tests use the registered position at the click edge; region bounds are inclusive.
  - PLAY hit: BTN_X_MIN<=xpos<=BTN_X_MAX and PLAY_Y_MIN<=ypos<=PLAY_Y_MAX.
  - CREDITS hit uses the same x range with the CRED_Y bounds.
  - A click outside both regions is ignored.
- Button: 2-flop synchroniser, then a counter that restarts on any level change. A press event is a single pulse when the synchronised level has been high for DEBOUNCE_CYCLES consecutive cycles. Re-arms only after the level is seen low.
- States: MENU, GAME, CREDITS, WAIT_FS, BLANK. Register `target` holds the destination screen.
  - MENU: PLAY hit -> target=GAME, go to WAIT_FS. CREDITS hit -> target=CREDITS, go to WAIT_FS. Button ignored.
  - GAME: button press or game_over=1 -> target=MENU, go to WAIT_FS. Simultaneous events cause exactly one transition.
  - CREDITS: button press or click anywhere -> target=MENU, go to WAIT_FS.
  - WAIT_FS: on fs -> BLANK, frame counter=0.
  - BLANK: on each fs the counter increments. When counter reaches BLANK_FRAMES-1 and fs occurs, the FSM enters target state and screen_sel=target.
- Outputs: busy=1 in WAIT_FS and BLANK. blank_out=1 in BLANK only.
- Output latency:
  - blank_out rises on the cycle after the first fs following the request.
  - screen_sel changes and blank_out falls in the same cycle, one cycle after the (BLANK_FRAMES+1)-th fs following the request.
- game_rst:
  - 1 in MENU and CREDITS.
  - 1 in WAIT_FS/BLANK regardless of target.
  - 0 only in GAME, so the game always starts fresh.
- Events arriving in WAIT_FS/BLANK are discarded, not queued. A debounced press that completes during BLANK is lost.
- Reset asserted mid-transition returns immediately to MENU with blank_out=0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `pong_pkg`: screen codes SCR_MENU/SCR_GAME/SCR_CREDITS (2-bit); menu button geometry constants reused by the menu renderer.
- One sub-module `btn_debounce` (synchroniser, counter, press pulse; parameter DEBOUNCE_CYCLES). The FSM and hit tests stay in screen_seq.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, BLANK_FRAMES=2, short synthetic frames.)
1. Reset, then click at (400,100) -> WAIT_FS, busy=1. Next fs -> blank_out=1. Two more fs -> screen_sel=1, blank_out=0, game_rst=0.
2. In MENU, click at (361,100) and at (400,147) -> no state change. Click at (674,622) -> ends in CREDITS (screen_sel=2) after 3 fs.
3. In GAME, button bounces 1-0-1 with highs under 4 cycles -> no transition. Held 4 cycles -> single return to MENU; held 1000 cycles -> still exactly one transition.
4. In GAME, game_over and debounced press in the same cycle -> exactly one transition to MENU. game_rst=1 from the next cycle.
5. During BLANK toward GAME, click CREDITS region and press button -> ignored; final screen_sel=1.
6. rst pulled low while in BLANK -> same cycle, asynchronously: screen_sel=0, blank_out=0, busy=0, game_rst=1. Release, then click PLAY -> normal transition.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared screen codes, sequencer states and menu button geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    SCR_MENU    = 2'd0,
    SCR_GAME    = 2'd1,
    SCR_CREDITS = 2'd2
  } screen_t;

  typedef enum logic [2:0] {
    ST_MENU,
    ST_GAME,
    ST_CREDITS,
    ST_WAIT_FS,
    ST_BLANK
  } state_t;

  // Menu button geometry, inclusive bounds in pixels; also used by the menu renderer.
  localparam logic [11:0] BTN_X_MIN  = 12'd362;
  localparam logic [11:0] BTN_X_MAX  = 12'd674;
  localparam logic [11:0] PLAY_Y_MIN = 12'd46;
  localparam logic [11:0] PLAY_Y_MAX = 12'd146;
  localparam logic [11:0] CRED_Y_MIN = 12'd622;
  localparam logic [11:0] CRED_Y_MAX = 12'd722;

  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y,
                                  input logic [11:0] x_min, input logic [11:0] x_max,
                                  input logic [11:0] y_min, input logic [11:0] y_max);
    return (x >= x_min) && (x <= x_max) && (y >= y_min) && (y <= y_max);
  endfunction

endpackage

// File: rtl/screen_seq_if.sv
// Sequencer inputs from timing/mouse/board/game and screen-control outputs to the video mux.
interface screen_seq_if;
  logic        vblnk_in;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        button;
  logic        game_over;
  logic [1:0]  screen_sel;
  logic        blank_out;
  logic        game_rst;
  logic        busy;

  modport master (
    output vblnk_in, mouse_left, xpos, ypos, button, game_over,
    input  screen_sel, blank_out, game_rst, busy
  );

  modport slave (
    input  vblnk_in, mouse_left, xpos, ypos, button, game_over,
    output screen_sel, blank_out, game_rst, busy
  );
endinterface

// File: rtl/screen_seq_debounce.sv
// Board button debouncer: 2-flop synchroniser, stability counter, single press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  // Synchronise the asynchronous button level into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // Count consecutive high cycles; a low level clears the count and re-arms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      armed <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (!s2) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else if (armed) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          press <= 1'b1;
          armed <= 1'b0;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/screen_seq.sv
// Frame-synchronous menu/game/credits screen sequencer with blanking between screens.
module screen_seq
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned BLANK_FRAMES    = 2
) (
  input  logic         clk,
  input  logic         rst,
  screen_seq_if.slave  bus
);

  logic        vb_q, vb_qq, ml_q, ml_qq;
  logic [11:0] x_q, y_q;
  logic        fs, click, play_hit, cred_hit, press;

  state_t      state, state_n;
  screen_t     target, target_n;
  logic [3:0]  fcnt, fcnt_n;
  screen_t     sel_q, sel_n;
  logic        blank_q, blank_n, grst_q, grst_n, busy_q, busy_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .button (bus.button),
    .press  (press)
  );

  // Register vblank, mouse button and position so edges and hit tests use registered values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vb_q  <= 1'b0;
      vb_qq <= 1'b0;
      ml_q  <= 1'b0;
      ml_qq <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      vb_q  <= bus.vblnk_in;
      vb_qq <= vb_q;
      ml_q  <= bus.mouse_left;
      ml_qq <= ml_q;
      x_q   <= bus.xpos;
      y_q   <= bus.ypos;
    end
  end

  assign fs       = vb_q & ~vb_qq;
  assign click    = ml_q & ~ml_qq;
  assign play_hit = in_box(x_q, y_q, BTN_X_MIN, BTN_X_MAX, PLAY_Y_MIN, PLAY_Y_MAX);
  assign cred_hit = in_box(x_q, y_q, BTN_X_MIN, BTN_X_MAX, CRED_Y_MIN, CRED_Y_MAX);

  // State, destination, frame counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_MENU;
      target  <= SCR_MENU;
      fcnt    <= '0;
      sel_q   <= SCR_MENU;
      blank_q <= 1'b0;
      grst_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      target  <= target_n;
      fcnt    <= fcnt_n;
      sel_q   <= sel_n;
      blank_q <= blank_n;
      grst_q  <= grst_n;
      busy_q  <= busy_n;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_n  = state;
    target_n = target;
    fcnt_n   = fcnt;
    sel_n    = sel_q;
    unique case (state)
      ST_MENU: begin
        if (click && play_hit) begin
          target_n = SCR_GAME;
          state_n  = ST_WAIT_FS;
        end else if (click && cred_hit) begin
          target_n = SCR_CREDITS;
          state_n  = ST_WAIT_FS;
        end
      end
      ST_GAME: begin
        if (press || bus.game_over) begin
          target_n = SCR_MENU;
          state_n  = ST_WAIT_FS;
        end
      end
      ST_CREDITS: begin
        if (press || click) begin
          target_n = SCR_MENU;
          state_n  = ST_WAIT_FS;
        end
      end
      ST_WAIT_FS: begin
        if (fs) begin
          state_n = ST_BLANK;
          fcnt_n  = '0;
        end
      end
      ST_BLANK: begin
        if (fs) begin
          if (fcnt == 4'(BLANK_FRAMES - 1)) begin
            sel_n = target;
            case (target)
              SCR_GAME:    state_n = ST_GAME;
              SCR_CREDITS: state_n = ST_CREDITS;
              default:     state_n = ST_MENU;
            endcase
          end else begin
            fcnt_n = fcnt + 4'd1;
          end
        end
      end
      default: state_n = ST_MENU;
    endcase
    blank_n = (state_n == ST_BLANK);
    busy_n  = (state_n == ST_WAIT_FS) || (state_n == ST_BLANK);
    grst_n  = (state_n != ST_GAME);
  end

  assign bus.screen_sel = sel_q;
  assign bus.blank_out  = blank_q;
  assign bus.game_rst   = grst_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_screen_seq.sv
// Directed bench for screen_seq with short debounce and synthetic frames.
module tb_screen_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  screen_seq_if bus_if ();

  screen_seq #(
    .DEBOUNCE_CYCLES (4),
    .BLANK_FRAMES    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        busy;
    logic [1:0]  sel;
    logic        grst;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus_if.vblnk_in = 1'b0;
    bus_if.mouse_left = 1'b0;
    bus_if.xpos = '0;
    bus_if.ypos = '0;
    bus_if.button = 1'b0;
    bus_if.game_over = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic fs_pulse();
    bus_if.vblnk_in = 1'b1;
    tick();
    bus_if.vblnk_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic click(input logic [11:0] x, input logic [11:0] y);
    bus_if.xpos = x;
    bus_if.ypos = y;
    bus_if.mouse_left = 1'b1;
    tick();
    tick();
    bus_if.mouse_left = 1'b0;
    tick();
    tick();
  endtask

  task automatic hold_button(input int unsigned n);
    bus_if.button = 1'b1;
    repeat (n) tick();
    bus_if.button = 1'b0;
  endtask

  task automatic go_game();
    click(12'd400, 12'd100);
    fs_pulse();
    fs_pulse();
    fs_pulse();
  endtask

  initial begin
    vecs[0] = '{12'd400, 12'd100, 1'b1, 2'd1, 1'b0};
    vecs[1] = '{12'd361, 12'd100, 1'b0, 2'd0, 1'b1};
    vecs[2] = '{12'd400, 12'd147, 1'b0, 2'd0, 1'b1};
    vecs[3] = '{12'd674, 12'd622, 1'b1, 2'd2, 1'b1};
    vecs[4] = '{12'd362, 12'd46,  1'b1, 2'd1, 1'b0};
    vecs[5] = '{12'd675, 12'd700, 1'b0, 2'd0, 1'b1};
    vecs[6] = '{12'd500, 12'd722, 1'b1, 2'd2, 1'b1};
    vecs[7] = '{12'd500, 12'd723, 1'b0, 2'd0, 1'b1};
    vecs[8] = '{12'd500, 12'd400, 1'b0, 2'd0, 1'b1};

    // Reset values and precise latency of a PLAY transition.
    do_reset();
    chk("rst_sel", bus_if.screen_sel, 2'd0);
    chk("rst_blank", bus_if.blank_out, 1'b0);
    chk("rst_grst", bus_if.game_rst, 1'b1);
    chk("rst_busy", bus_if.busy, 1'b0);
    click(12'd400, 12'd100);
    chk("t1_busy", bus_if.busy, 1'b1);
    chk("t1_blank_pre", bus_if.blank_out, 1'b0);
    bus_if.vblnk_in = 1'b1;
    tick();
    chk("t1_blank_early", bus_if.blank_out, 1'b0);
    bus_if.vblnk_in = 1'b0;
    tick();
    chk("t1_blank_rise", bus_if.blank_out, 1'b1);
    tick();
    fs_pulse();
    chk("t1_blank_mid", bus_if.blank_out, 1'b1);
    chk("t1_sel_mid", bus_if.screen_sel, 2'd0);
    bus_if.vblnk_in = 1'b1;
    tick();
    bus_if.vblnk_in = 1'b0;
    tick();
    chk("t1_sel", bus_if.screen_sel, 2'd1);
    chk("t1_blank_fall", bus_if.blank_out, 1'b0);
    chk("t1_grst", bus_if.game_rst, 1'b0);
    chk("t1_busy_end", bus_if.busy, 1'b0);

    // Menu hit-test table.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      click(vecs[i].x, vecs[i].y);
      chk($sformatf("v%0d_busy", i), bus_if.busy, vecs[i].busy);
      fs_pulse();
      chk($sformatf("v%0d_blank", i), bus_if.blank_out, vecs[i].busy);
      fs_pulse();
      fs_pulse();
      chk($sformatf("v%0d_sel", i), bus_if.screen_sel, vecs[i].sel);
      chk($sformatf("v%0d_grst", i), bus_if.game_rst, vecs[i].grst);
      chk($sformatf("v%0d_idle", i), bus_if.busy, 1'b0);
    end

    // Credits: any click returns to menu; button ignored in menu.
    do_reset();
    click(12'd500, 12'd700);
    fs_pulse(); fs_pulse(); fs_pulse();
    chk("cr_sel", bus_if.screen_sel, 2'd2);
    click(12'd10, 12'd10);
    chk("cr_click_busy", bus_if.busy, 1'b1);
    fs_pulse(); fs_pulse(); fs_pulse();
    chk("cr_back", bus_if.screen_sel, 2'd0);
    hold_button(6);
    repeat (6) tick();
    chk("menu_btn_ign", bus_if.busy, 1'b0);

    // Bouncing button in GAME, then a valid press, then a long hold.
    do_reset();
    go_game();
    hold_button(3);
    repeat (2) tick();
    hold_button(2);
    repeat (8) tick();
    chk("bounce_busy", bus_if.busy, 1'b0);
    chk("bounce_sel", bus_if.screen_sel, 2'd1);
    hold_button(4);
    repeat (4) tick();
    chk("press_busy", bus_if.busy, 1'b1);
    fs_pulse(); fs_pulse(); fs_pulse();
    chk("press_sel", bus_if.screen_sel, 2'd0);
    go_game();
    bus_if.button = 1'b1;
    repeat (10) tick();
    chk("hold_busy", bus_if.busy, 1'b1);
    fs_pulse(); fs_pulse(); fs_pulse();
    chk("hold_sel", bus_if.screen_sel, 2'd0);
    go_game();
    repeat (900) tick();
    chk("hold_norearm_busy", bus_if.busy, 1'b0);
    chk("hold_norearm_sel", bus_if.screen_sel, 2'd1);
    bus_if.button = 1'b0;
    repeat (4) tick();

    // game_over coincident with a debounced press.
    do_reset();
    go_game();
    hold_button(4);
    tick();
    tick();
    chk("go_grst_before", bus_if.game_rst, 1'b0);
    bus_if.game_over = 1'b1;
    tick();
    bus_if.game_over = 1'b0;
    chk("go_grst_after", bus_if.game_rst, 1'b1);
    chk("go_busy", bus_if.busy, 1'b1);
    fs_pulse(); fs_pulse(); fs_pulse();
    chk("go_sel", bus_if.screen_sel, 2'd0);
    repeat (6) tick();
    chk("go_single", bus_if.busy, 1'b0);

    // Events during BLANK toward GAME are discarded.
    do_reset();
    click(12'd400, 12'd100);
    fs_pulse();
    chk("blk_in_blank", bus_if.blank_out, 1'b1);
    click(12'd500, 12'd700);
    hold_button(4);
    repeat (6) tick();
    fs_pulse(); fs_pulse();
    chk("blk_sel", bus_if.screen_sel, 2'd1);
    repeat (6) tick();
    chk("blk_lost_press", bus_if.busy, 1'b0);

    // Asynchronous reset while blanking.
    do_reset();
    click(12'd400, 12'd100);
    fs_pulse();
    chk("ar_pre_blank", bus_if.blank_out, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_sel", bus_if.screen_sel, 2'd0);
    chk("ar_blank", bus_if.blank_out, 1'b0);
    chk("ar_busy", bus_if.busy, 1'b0);
    chk("ar_grst", bus_if.game_rst, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    go_game();
    chk("ar_recover", bus_if.screen_sel, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
